// File: rtl/fifo_pkg.sv
// Shared constants and status bundle for the parametrised sync FIFO.
// Imported by the RTL and reused by monitors/scoreboards.
package fifo_pkg;

    localparam int FIFO_DATA_WIDTH = 8;
    localparam int FIFO_DEPTH      = 16;
    localparam int FIFO_AF_MARGIN  = 2;
    localparam int FIFO_AE_MARGIN  = 2;

    typedef struct packed {
        logic empty;
        logic almost_empty;
        logic almost_full;
        logic full;
    } fifo_status_t;

endpackage

// File: rtl/fifo_sync_param_if.sv
// Producer/consumer bundle of the parametrised sync FIFO.
// master = traffic side, slave = FIFO side.
interface fifo_sync_param_if
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int DEPTH      = FIFO_DEPTH
);

    localparam int ADDR_W = $clog2(DEPTH);

    logic                  wn;
    logic                  rn;
    logic [DATA_WIDTH-1:0] data_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  empty;
    logic                  full;
    logic                  almost_empty;
    logic                  almost_full;
    logic [ADDR_W:0]       count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output wn, rn, data_in,
        input  data_out, empty, full, almost_empty,
        input  almost_full, count, overflow, underflow
    );

    modport slave (
        input  wn, rn, data_in,
        output data_out, empty, full, almost_empty,
        output almost_full, count, overflow, underflow
    );

endinterface

// File: rtl/fifo_mem.sv
// Dual-port register file: synchronous write, registered read.
// No reset; the read register holds when rd_en is low.
module fifo_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    localparam int ADDR_W    = $clog2(DEPTH)
) (
    input  logic                  clock,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q;

    // Same-slot read+write returns the old entry (full-FIFO pass case)
    always_ff @(posedge clock) begin
        if (wr_en) mem_q[wr_addr] <= wr_data;
        if (rd_en) rd_data_q <= mem_q[rd_addr];
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised synchronous FIFO with occupancy count, watermarks
// and registered overflow/underflow pulses.
module fifo_sync_param
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int DEPTH      = FIFO_DEPTH,
    parameter int AF_MARGIN  = FIFO_AF_MARGIN,
    parameter int AE_MARGIN  = FIFO_AE_MARGIN
) (
    input  logic             clock,
    input  logic             reset,
    fifo_sync_param_if.slave bus
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = ADDR_W + 1;

    localparam logic [CNT_W-1:0] FULL_LVL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_LVL   = CNT_W'(DEPTH - AF_MARGIN);
    localparam logic [CNT_W-1:0] AE_LVL   = CNT_W'(AE_MARGIN);

    logic [ADDR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  ovf_q, ovf_d;
    logic                  udf_q, udf_d;
    logic                  zero_q, zero_d;
    logic                  wr_en, rd_en;
    logic [DATA_WIDTH-1:0] rd_data;
    fifo_status_t          st;

    always_comb begin
        st.empty        = (cnt_q == '0);
        st.almost_empty = (cnt_q <= AE_LVL);
        st.almost_full  = (cnt_q >= AF_LVL);
        st.full         = (cnt_q == FULL_LVL);
    end

    always_comb begin
        wr_en    = bus.wn && (!st.full || bus.rn);
        rd_en    = bus.rn && !st.empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        if (rd_en) rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        unique case ({wr_en, rd_en})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
        ovf_d  = bus.wn && st.full && !bus.rn;
        udf_d  = bus.rn && st.empty;
        // Mask the unreset read register until the first real read
        zero_d = zero_q && !rd_en;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
            zero_q   <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
            zero_q   <= zero_d;
        end
    end

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clock   (clock),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr_q),
        .wr_data (bus.data_in),
        .rd_en   (rd_en),
        .rd_addr (rd_ptr_q),
        .rd_data (rd_data)
    );

    assign bus.data_out     = zero_q ? '0 : rd_data;
    assign bus.empty        = st.empty;
    assign bus.almost_empty = st.almost_empty;
    assign bus.almost_full  = st.almost_full;
    assign bus.full         = st.full;
    assign bus.count        = cnt_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = udf_q;

endmodule
